// File: rtl/fios_result_collector.sv
// Collects the word-serial Montgomery result from the last FIOS PE, applies the
// final conditional subtraction with a running borrow, and hands the reduced value out.
module fios_result_collector #(
    parameter int unsigned WORD_WIDTH = 17,
    parameter int unsigned WORD_COUNT = 16
) (
    input  logic                             clock_i,
    input  logic                             reset_i,
    input  logic                             start_i,
    input  logic                             word_valid_i,
    input  logic [WORD_WIDTH-1:0]            word_i,
    input  logic [WORD_WIDTH*WORD_COUNT-1:0] p_i,
    output logic [WORD_WIDTH*WORD_COUNT-1:0] result_o,
    output logic                             result_valid_o,
    input  logic                             result_ready_i,
    output logic                             busy_o,
    output logic                             overrun_o
);

    localparam int unsigned RES_W = WORD_WIDTH * WORD_COUNT;
    localparam int unsigned K_W   = $clog2(WORD_COUNT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    state_t                state_q;
    logic [K_W-1:0]        k_q;
    logic                  borrow_q;
    logic [RES_W-1:0]      raw_q;
    logic [RES_W-1:0]      diff_q;

    logic [WORD_WIDTH-1:0] p_word_c;
    logic [WORD_WIDTH:0]   sub_c;
    logic                  last_word_c;
    logic                  sel_diff_c;

    // Modulus word matching the current word index; p_i is held stable by the producer.
    always_comb begin
        p_word_c = '0;
        for (int i = 0; i < int'(WORD_COUNT); i++) begin
            if (k_q == K_W'(i)) begin
                p_word_c = p_i[i*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    // One borrow-chain step, one bit wider than the word so the borrow falls out on top.
    always_comb begin
        sub_c       = {1'b0, word_i} - {1'b0, p_word_c} - (WORD_WIDTH+1)'(borrow_q);
        last_word_c = (k_q == K_W'(WORD_COUNT));
        // Top carry set means R >= 2^RES_W > p; no final borrow means low part >= p.
        sel_diff_c  = word_i[0] | ~borrow_q;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q        <= IDLE;
            k_q            <= '0;
            borrow_q       <= 1'b0;
            raw_q          <= '0;
            diff_q         <= '0;
            result_o       <= '0;
            result_valid_o <= 1'b0;
            busy_o         <= 1'b0;
            overrun_o      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q   <= COLLECT;
                        busy_o    <= 1'b1;
                        k_q       <= '0;
                        borrow_q  <= 1'b0;
                        raw_q     <= '0;
                        diff_q    <= '0;
                        overrun_o <= 1'b0;
                    end else if (word_valid_i) begin
                        overrun_o <= 1'b1;
                    end
                end

                COLLECT: begin
                    if (start_i) begin
                        // Restart: any word presented alongside start is discarded.
                        k_q       <= '0;
                        borrow_q  <= 1'b0;
                        raw_q     <= '0;
                        diff_q    <= '0;
                        overrun_o <= 1'b0;
                    end else if (word_valid_i) begin
                        if (last_word_c) begin
                            result_o       <= sel_diff_c ? diff_q : raw_q;
                            result_valid_o <= 1'b1;
                            state_q        <= OUTPUT;
                        end else begin
                            for (int i = 0; i < int'(WORD_COUNT); i++) begin
                                if (k_q == K_W'(i)) begin
                                    raw_q[i*WORD_WIDTH +: WORD_WIDTH]  <= word_i;
                                    diff_q[i*WORD_WIDTH +: WORD_WIDTH] <= sub_c[WORD_WIDTH-1:0];
                                end
                            end
                            borrow_q <= sub_c[WORD_WIDTH];
                            k_q      <= k_q + K_W'(1);
                        end
                    end
                end

                OUTPUT: begin
                    if (word_valid_i) begin
                        overrun_o <= 1'b1;
                    end
                    if (result_ready_i) begin
                        result_valid_o <= 1'b0;
                        if (start_i) begin
                            state_q   <= COLLECT;
                            k_q       <= '0;
                            borrow_q  <= 1'b0;
                            raw_q     <= '0;
                            diff_q    <= '0;
                            overrun_o <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            busy_o  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state_q        <= IDLE;
                    busy_o         <= 1'b0;
                    result_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fios_result_collector.md
Name: fios_result_collector

Overview:
- Sits at the output end of the FIOS systolic PE chain.
- Consumes the word-serial Montgomery result stream (17-bit words, LSW first, plus one top-carry word) emitted by the last PE.
- Performs the final conditional subtraction (if R >= p then R - p) on the fly with a borrow chain, and presents the fully reduced parallel result through a valid/ready handshake.
- It is the parallel-side counterpart to the word-serial feed into the chain.

Parameters:
WORD_WIDTH, 17, bits per result word (matches the PE datapath word)
WORD_COUNT, 16, number of modulus words N; result width = WORD_WIDTH*WORD_COUNT

Ports:
clock_i  in  1  system clock, all state on rising edge
reset_i  in  1  asynchronous active-high reset
start_i  in  1  arms the collector for a new result (one-cycle pulse)
word_valid_i  in  1  word_i carries a result word this cycle (no backpressure possible)
word_i  in  WORD_WIDTH  result word from PE chain, LSW first
p_i  in  WORD_WIDTH*WORD_COUNT  modulus; must be stable from start_i until result_valid_o
result_o  out  WORD_WIDTH*WORD_COUNT  reduced result
result_valid_o  out  1  result_o valid; held until accepted
result_ready_i  in  1  consumer accepts result_o
busy_o  out  1  high in COLLECT or OUTPUT
overrun_o  out  1  sticky: word arrived while not collecting

Behaviour:
- Reset (async, any state): state=IDLE, word counter=0, borrow=0, raw/diff registers=0, result_o=0, result_valid_o=0, busy_o=0, overrun_o=0.
- States: IDLE, COLLECT, OUTPUT.
- IDLE:
  - start_i -> COLLECT; clear counter k, borrow, and overrun_o.
  - word_valid_i without start_i sets overrun_o; the word is dropped.
- COLLECT, for each word_valid_i with k < WORD_COUNT:
  - raw[k] <= word_i.
  - {b', d} = word_i - p_i word k - borrow, computed WORD_WIDTH+1 wide.
  - diff[k] <= d; borrow <= b'; k <= k+1.
- COLLECT, word with k == WORD_COUNT (top-carry word):
  - Only bit 0 (t) is used; bits [WORD_WIDTH-1:1] are ignored.
  - sel_diff = t | ~borrow.
  - result_o <= sel_diff ? diff : raw.
  - result_valid_o <= 1 next cycle; state -> OUTPUT.
- Latency: result_valid_o rises exactly 1 cycle after the top word is accepted. Total collection takes WORD_COUNT+1 valid words; gaps in word_valid_i are allowed.
- start_i during COLLECT restarts: counter, borrow and partials are cleared, and any word on that cycle is discarded.
- OUTPUT:
  - result_o and result_valid_o stay stable until result_ready_i.
  - On the handshake, result_valid_o drops next cycle and state -> IDLE. If start_i is also high that cycle, state -> COLLECT directly (back-to-back).
  - start_i without result_ready_i is ignored.
  - word_valid_i sets overrun_o; the word is dropped and the result is unchanged.
- busy_o = (state != IDLE).
- Arithmetic:
  - Unsigned. Input range 0 <= R < 2p is a precondition.
  - Output is R mod p for R < 2p.
  - If R >= 2p, output is R - p truncated to WORD_WIDTH*WORD_COUNT bits, with no error flag.
- p_i is read combinationally per word index; it is not registered.

Test Plan (WORD_WIDTH=17, WORD_COUNT=2, p = {17'h00001, 17'h00003} = 0x20003):
- start, words 0x00005, 0x00000, 0x00000 -> result_o=0x000000005 (raw path), result_valid_o 1 cycle after third word.
- start, words 0x0000A, 0x00001, 0x00000 (R=p+7) -> result_o=0x000000007.
- start, words 0x00003, 0x00001, 0x00000 (R=p) -> result_o=0.
- start, words 0x00002, 0x00000, 0x00001 (R=2^34+2) -> result_o=0x3FFFDFFFF (top bit forces the diff path).
- Hold result_ready_i=0 for 3 cycles, then drive word_valid_i=1 -> result_o unchanged, overrun_o=1. Then ready=1 together with start_i=1 -> COLLECT next cycle, overrun_o cleared.
- Assert reset_i after 1 word of collection -> all outputs 0 immediately (asynchronously). Then a full sequence as in scenario 2 -> 0x000000007.
